// File: rtl/line_motor_pwm.sv
// line_motor_pwm: steering FSM picking per-motor target duties, slewed duties, glitch-free PWM.
// Optional MOTOR_SEARCH_EN: when the line is lost, pivot toward the last turn direction instead of stopping.
module line_motor_pwm #(
  parameter int unsigned         PWM_BITS  = 8,
  parameter logic [15:0]         RAMP_DIV  = 16'd1000,
  parameter logic [PWM_BITS-1:0] DUTY_FAST = 8'd200,
  parameter logic [PWM_BITS-1:0] DUTY_SLOW = 8'd60
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                sensorLeft,
  input  logic                sensorRight,
  output logic                pwmLeft,
  output logic                pwmRight,
  output logic [2:0]          steerState,
  output logic [PWM_BITS-1:0] dutyLeft,
  output logic [PWM_BITS-1:0] dutyRight
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FORWARD    = 3'd1,
    TURN_LEFT  = 3'd2,
    TURN_RIGHT = 3'd3,
    SEARCH     = 3'd4
  } steer_t;

  localparam logic [PWM_BITS-1:0] ONE = {{(PWM_BITS-1){1'b0}}, 1'b1};

  steer_t state;
`ifdef MOTOR_SEARCH_EN
  logic last_dir;  // 0 = left, 1 = right
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
`ifdef MOTOR_SEARCH_EN
      last_dir <= 1'b0;
`endif
    end else begin
      if (!enable) begin
        state <= IDLE;
      end else begin
        unique case ({sensorLeft, sensorRight})
          2'b11: state <= FORWARD;
          2'b10: state <= TURN_LEFT;
          2'b01: state <= TURN_RIGHT;
`ifdef MOTOR_SEARCH_EN
          2'b00: state <= SEARCH;
`else
          2'b00: state <= IDLE;
`endif
        endcase
      end
`ifdef MOTOR_SEARCH_EN
      // Exactly one sensor set means a turn is being entered; sensorRight is the direction.
      if (enable && (sensorLeft ^ sensorRight))
        last_dir <= sensorRight;
`endif
    end
  end

  assign steerState = state;

  logic [PWM_BITS-1:0] target_left, target_right;

  always_comb begin
    target_left  = '0;
    target_right = '0;
    unique case (state)
      FORWARD: begin
        target_left  = DUTY_FAST;
        target_right = DUTY_FAST;
      end
      TURN_LEFT: begin
        target_left  = DUTY_SLOW;
        target_right = DUTY_FAST;
      end
      TURN_RIGHT: begin
        target_left  = DUTY_FAST;
        target_right = DUTY_SLOW;
      end
`ifdef MOTOR_SEARCH_EN
      SEARCH: begin
        target_left  = last_dir ? DUTY_FAST : DUTY_SLOW;
        target_right = last_dir ? DUTY_SLOW : DUTY_FAST;
      end
`endif
      default: begin
        target_left  = '0;
        target_right = '0;
      end
    endcase
  end

  logic [15:0] prescale;
  logic        tick;

  assign tick = (prescale == RAMP_DIV - 16'd1);

  function automatic logic [PWM_BITS-1:0] step_toward(input logic [PWM_BITS-1:0] cur,
                                                       input logic [PWM_BITS-1:0] tgt);
    if (cur < tgt)
      return cur + ONE;
    else if (cur > tgt)
      return cur - ONE;
    return cur;
  endfunction

  // Targets are combinational from the current state, so a tick in the same cycle
  // as a state change still steps toward the old target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale  <= '0;
      dutyLeft  <= '0;
      dutyRight <= '0;
    end else begin
      prescale <= tick ? '0 : prescale + 16'd1;
      if (tick) begin
        dutyLeft  <= step_toward(dutyLeft, target_left);
        dutyRight <= step_toward(dutyRight, target_right);
      end
    end
  end

  logic [PWM_BITS-1:0] counter, shadow_left, shadow_right;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter      <= '0;
      shadow_left  <= '0;
      shadow_right <= '0;
      pwmLeft      <= 1'b0;
      pwmRight     <= 1'b0;
    end else begin
      counter <= counter + ONE;
      if (counter == '1) begin
        shadow_left  <= dutyLeft;
        shadow_right <= dutyRight;
      end
      pwmLeft  <= (counter < shadow_left);
      pwmRight <= (counter < shadow_right);
    end
  end

endmodule

// File: tb/tb_line_motor_pwm.sv
// Bench for line_motor_pwm: cycle-level arithmetic model checked every cycle, plus directed literal checks.
// Builds with or without MOTOR_SEARCH_EN; expectations follow the macro.
module tb_line_motor_pwm;

  localparam int FAST   = 12;
  localparam int SLOW   = 4;
  localparam int DIV    = 2;
  localparam int PERIOD = 16;
`ifdef MOTOR_SEARCH_EN
  localparam bit SEARCH_EN = 1'b1;
`else
  localparam bit SEARCH_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, enable, sensorLeft, sensorRight;
  logic       pwmLeft, pwmRight;
  logic [2:0] steerState;
  logic [3:0] dutyLeft, dutyRight;

  int n_assert = 0;
  int n_fail   = 0;

  line_motor_pwm #(
    .PWM_BITS (4),
    .RAMP_DIV (16'd2),
    .DUTY_FAST(4'd12),
    .DUTY_SLOW(4'd4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .sensorLeft (sensorLeft),
    .sensorRight(sensorRight),
    .pwmLeft    (pwmLeft),
    .pwmRight   (pwmRight),
    .steerState (steerState),
    .dutyLeft   (dutyLeft),
    .dutyRight  (dutyRight)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  // Model: cycles since reset give PWM phase and tick; duties move one unit per tick.
  int m_cyc = 0, m_state = 0, m_ldir = 0;
  int m_dl = 0, m_dr = 0, m_sl = 0, m_sr = 0, m_pl = 0, m_pr = 0;
  int m_cnt = 0, m_tl = 0, m_tr = 0;

  function automatic int toward(input int cur, input int tgt);
    if (cur < tgt) return cur + 1;
    if (cur > tgt) return cur - 1;
    return cur;
  endfunction

  function automatic int target_of(input int st, input int ldir, input bit left);
    case (st)
      1:       return FAST;
      2:       return left ? SLOW : FAST;
      3:       return left ? FAST : SLOW;
      4:       return ((ldir == 0) == left) ? SLOW : FAST;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc = 0; m_state = 0; m_ldir = 0;
      m_dl = 0; m_dr = 0; m_sl = 0; m_sr = 0; m_pl = 0; m_pr = 0;
    end else begin
      m_cnt = m_cyc % PERIOD;
      m_pl  = (m_cnt < m_sl) ? 1 : 0;
      m_pr  = (m_cnt < m_sr) ? 1 : 0;
      if (m_cnt == PERIOD - 1) begin
        m_sl = m_dl;
        m_sr = m_dr;
      end
      if ((m_cyc % DIV) == DIV - 1) begin
        m_tl = target_of(m_state, m_ldir, 1'b1);
        m_tr = target_of(m_state, m_ldir, 1'b0);
        m_dl = toward(m_dl, m_tl);
        m_dr = toward(m_dr, m_tr);
      end
      if (!enable) m_state = 0;
      else if (sensorLeft && sensorRight) m_state = 1;
      else if (sensorLeft) begin m_state = 2; m_ldir = 0; end
      else if (sensorRight) begin m_state = 3; m_ldir = 1; end
      else m_state = SEARCH_EN ? 4 : 0;
      m_cyc++;
    end
  end

  always @(posedge clk) begin
    #1;
    chk("steer_state", int'(steerState), m_state);
    chk("duty_left",   int'(dutyLeft),   m_dl);
    chk("duty_right",  int'(dutyRight),  m_dr);
    chk("pwm_left",    int'(pwmLeft),    m_pl);
    chk("pwm_right",   int'(pwmRight),   m_pr);
  end

  task automatic count_high(input int n, output int hl, output int hr);
    hl = 0;
    hr = 0;
    repeat (n) begin
      @(negedge clk);
      if (pwmLeft)  hl++;
      if (pwmRight) hr++;
    end
  endtask

  task automatic set_sensors(input logic l, input logic r);
    sensorLeft  = l;
    sensorRight = r;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hl, hr, guard;
    rst_n = 1'b0; enable = 1'b1; set_sensors(1'b1, 1'b1);
    repeat (3) @(negedge clk);
    chk("reset_state", int'(steerState), 0);
    chk("reset_duty_left", int'(dutyLeft), 0);
    chk("reset_duty_right", int'(dutyRight), 0);
    chk("reset_pwm_left", int'(pwmLeft), 0);
    chk("reset_pwm_right", int'(pwmRight), 0);

    // Ramp up to FORWARD
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_state", int'(steerState), 1);
    repeat (9) @(negedge clk);
    chk("ramp_mid_left", int'(dutyLeft), 5);
    repeat (14) @(negedge clk);
    chk("ramp_full_left", int'(dutyLeft), 12);
    chk("ramp_full_right", int'(dutyRight), 12);
    repeat (8) @(negedge clk);

    // Turn left from steady forward
    set_sensors(1'b1, 1'b0);
    @(negedge clk);
    chk("turn_state", int'(steerState), 2);
    repeat (14) @(negedge clk);
    chk("turn_left_15", int'(dutyLeft), 5);
    @(negedge clk);
    chk("turn_left_16", int'(dutyLeft), 4);
    chk("turn_right_hold", int'(dutyRight), 12);
    repeat (32) @(negedge clk);
    count_high(16, hl, hr);
    chk("turn_pwm_left_high", hl, 4);
    chk("turn_pwm_right_high", hr, 12);

    // Disable mid-ramp at dutyLeft = 7
    set_sensors(1'b1, 1'b1);
    guard = 0;
    while (dutyLeft != 4'd7 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("reach_duty7", int'(dutyLeft), 7);
    enable = 1'b0;
    @(negedge clk);
    chk("disable_state", int'(steerState), 0);
    chk("disable_left_hold", int'(dutyLeft), 7);
    repeat (12) @(negedge clk);
    chk("disable_left_13", int'(dutyLeft), 1);
    @(negedge clk);
    chk("disable_left_14", int'(dutyLeft), 0);
    chk("disable_right_14", int'(dutyRight), 5);
    repeat (32) @(negedge clk);
    count_high(16, hl, hr);
    chk("disable_pwm_left_low", hl, 0);

    // Turn right, then lose the line
    enable = 1'b1;
    set_sensors(1'b0, 1'b1);
    @(negedge clk);
    chk("turn_right_state", int'(steerState), 3);
    repeat (39) @(negedge clk);
    chk("turn_right_left", int'(dutyLeft), 12);
    chk("turn_right_right", int'(dutyRight), 4);
    set_sensors(1'b0, 1'b0);
    @(negedge clk);
    chk("search_r_state", int'(steerState), SEARCH_EN ? 4 : 0);
    repeat (39) @(negedge clk);
    chk("search_r_left", int'(dutyLeft), SEARCH_EN ? 12 : 0);
    chk("search_r_right", int'(dutyRight), SEARCH_EN ? 4 : 0);

    // Turn left, then lose the line
    set_sensors(1'b1, 1'b0);
    repeat (40) @(negedge clk);
    set_sensors(1'b0, 1'b0);
    repeat (40) @(negedge clk);
    chk("search_l_left", int'(dutyLeft), SEARCH_EN ? 4 : 0);
    chk("search_l_right", int'(dutyRight), SEARCH_EN ? 12 : 0);

    // Target change mid-period: shadow only updates at the counter wrap
    set_sensors(1'b1, 1'b1);
    repeat (40) @(negedge clk);
    while ((m_cyc % PERIOD) != 8) @(negedge clk);
    set_sensors(1'b1, 1'b0);
    count_high(8, hl, hr);
    chk("glitch_rest_of_period", hl, 4);
    count_high(16, hl, hr);
    chk("glitch_next_period", hl, 9);

    // Async reset pulse mid-ramp
    set_sensors(1'b1, 1'b1);
    repeat (10) @(negedge clk);
    chk("pre_reset_left", int'(dutyLeft), 9);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_duty_left", int'(dutyLeft), 0);
    chk("async_duty_right", int'(dutyRight), 0);
    chk("async_pwm_left", int'(pwmLeft), 0);
    chk("async_pwm_right", int'(pwmRight), 0);
    chk("async_state", int'(steerState), 0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rerelease_state", int'(steerState), 1);
    repeat (23) @(negedge clk);
    chk("reramp_left", int'(dutyLeft), 12);
    chk("reramp_right", int'(dutyRight), 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
